// File: rtl/stream_arbiter.sv
// stream_arbiter: packet-level round-robin arbiter feeding one stream_upsize
// input from STREAM_COUNT narrow sources. A grant is held from arbitration
// until the beat carrying last is accepted. In BUSY the master side is a
// purely combinational pass-through of the granted source.
// Optional build macro STREAM_ARB_QOS_EN adds s_qos_i: the highest QoS among
// valid sources wins, and ties fall back to the round-robin scan order.
module stream_arbiter #(
    parameter int T_DATA_WIDTH = 4,
    parameter int STREAM_COUNT = 2,
    parameter int T_ID_WIDTH   = $clog2(STREAM_COUNT)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]  s_data_i,
    input  logic [STREAM_COUNT-1:0]                    s_last_i,
    input  logic [STREAM_COUNT-1:0]                    s_valid_i,
`ifdef STREAM_ARB_QOS_EN
    input  logic [STREAM_COUNT-1:0][1:0]               s_qos_i,
`endif
    output logic [STREAM_COUNT-1:0]                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                    m_data_o,
    output logic                                       m_last_o,
    output logic                                       m_valid_o,
    input  logic                                       m_ready_i,
    output logic [T_ID_WIDTH-1:0]                      m_id_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [T_ID_WIDTH-1:0] r_grant;
    logic [T_ID_WIDTH-1:0] r_rr_ptr;

    logic                  w_any;
    logic [T_ID_WIDTH-1:0] w_pick;
    logic [T_ID_WIDTH-1:0] w_cand;
`ifdef STREAM_ARB_QOS_EN
    logic [1:0]            w_best_qos;
`endif

    // Arbitration: scan rr_ptr+1, rr_ptr+2, ... (wrapping) and take the first
    // valid source; with QoS only a strictly higher level displaces an earlier
    // candidate, so ties resolve in round-robin order.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_cand = '0;
`ifdef STREAM_ARB_QOS_EN
        w_best_qos = '0;
`endif
        for (int unsigned i = 0; i < STREAM_COUNT; i++) begin
            w_cand = T_ID_WIDTH'((32'(r_rr_ptr) + i + 32'd1) % STREAM_COUNT);
            if (s_valid_i[w_cand]) begin
`ifdef STREAM_ARB_QOS_EN
                if (!w_any || (s_qos_i[w_cand] > w_best_qos)) begin
                    w_any      = 1'b1;
                    w_pick     = w_cand;
                    w_best_qos = s_qos_i[w_cand];
                end
`else
                if (!w_any) begin
                    w_any  = 1'b1;
                    w_pick = w_cand;
                end
`endif
            end
        end
    end

    // Next state and master/slave outputs; everything is quiet outside BUSY.
    always_comb begin
        w_state_nxt = r_state;
        s_ready_o   = '0;
        m_data_o    = '0;
        m_last_o    = 1'b0;
        m_valid_o   = 1'b0;
        m_id_o      = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                m_data_o           = s_data_i[r_grant];
                m_last_o           = s_last_i[r_grant];
                m_valid_o          = s_valid_i[r_grant];
                m_id_o             = r_grant;
                s_ready_o[r_grant] = m_ready_i;
                if (s_valid_i[r_grant] && m_ready_i && s_last_i[r_grant]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; reset points rr_ptr at the last source so source 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= T_ID_WIDTH'(STREAM_COUNT - 1);
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_any) begin
                r_grant  <= w_pick;
                r_rr_ptr <= w_pick;
            end
        end
    end

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter (STREAM_COUNT=2, T_DATA_WIDTH=4).
// Source models replay queued beats; the monitor pops expected beats on every
// master handshake. Build with STREAM_ARB_QOS_EN to include the QoS cases.
module tb_stream_arbiter;

    localparam int NS = 2;
    localparam int W  = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
        logic         id;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NS-1:0][W-1:0]  s_data_i = '0;
    logic [NS-1:0]         s_last_i = '0;
    logic [NS-1:0]         s_valid_i = '0;
`ifdef STREAM_ARB_QOS_EN
    logic [NS-1:0][1:0]    s_qos_i = '0;
`endif
    logic [NS-1:0]         s_ready_o;
    logic [W-1:0]          m_data_o;
    logic                  m_last_o;
    logic                  m_valid_o;
    logic                  m_ready_i = 1'b1;
    logic                  m_id_o;

    beat_t       src_q[NS][$];
    exp_t        exp_q[$];
    logic [NS-1:0] pause = '0;
    logic [NS-1:0] fire  = '0;

    int n_checks = 0;
    int n_fail   = 0;

    stream_arbiter #(
        .T_DATA_WIDTH (W),
        .STREAM_COUNT (NS),
        .T_ID_WIDTH   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
`ifdef STREAM_ARB_QOS_EN
        .s_qos_i   (s_qos_i),
`endif
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_id_o    (m_id_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int k, input logic [W-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        src_q[k].push_back(b);
    endtask

    task automatic expect_beat(input logic [W-1:0] d, input logic l, input logic id);
        exp_t e;
        e.d  = d;
        e.l  = l;
        e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string nm);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            tick();
            c++;
        end
        check(nm, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Samples m_valid_o once per cycle (mid-cycle) starting at the current cycle.
    task automatic sample_valid(input int n, output logic [15:0] v, output logic rdy0_seen);
        v = '0;
        rdy0_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            #4;
            v[i] = m_valid_o;
            if (s_ready_o[0]) rdy0_seen = 1'b1;
            tick();
        end
    endtask

    // Source models: pop on a handshake seen mid-cycle, then present the next head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NS; k++) begin
                if (fire[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
            end
            #2;
            for (int k = 0; k < NS; k++) begin
                if (src_q[k].size() != 0 && !pause[k]) begin
                    s_valid_i[k] = 1'b1;
                    s_data_i[k]  = src_q[k][0].d;
                    s_last_i[k]  = src_q[k][0].l;
                end else begin
                    s_valid_i[k] = 1'b0;
                    s_data_i[k]  = '0;
                    s_last_i[k]  = 1'b0;
                end
            end
            @(negedge clk);
            fire = rst ? '0 : (s_valid_i & s_ready_o);
        end
    end

    // Monitor: ready exclusivity every cycle, scoreboard compare on each handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("ready_only_granted", 32'(s_ready_o & ~(NS'(1) << m_id_o)), 32'd0);
                if (m_valid_o && m_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'({m_data_o, m_last_o, m_id_o}), 32'h0);
                        if ({m_data_o, m_last_o, m_id_o} == '0) begin
                            n_fail++;
                            $display("FAIL unexpected_beat: got beat with empty scoreboard, expected none");
                        end
                    end else begin
                        e = exp_q.pop_front();
                        check("beat{data,last,id}", 32'({m_data_o, m_last_o, m_id_o}),
                              32'({e.d, e.l, e.id}));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v;
        logic        r0;

        // Reset state
        #1;
        check("reset_outputs", 32'({m_valid_o, m_last_o, m_data_o, m_id_o, s_ready_o}), 32'd0);

        // Both sources valid from reset
        load(0, 4'h1, 1'b0); load(0, 4'h2, 1'b1);
        load(1, 4'hA, 1'b0); load(1, 4'hB, 1'b1);
        expect_beat(4'h1, 1'b0, 1'b0); expect_beat(4'h2, 1'b1, 1'b0);
        expect_beat(4'hA, 1'b0, 1'b1); expect_beat(4'hB, 1'b1, 1'b1);
        tick(); tick(); tick();
        check("reset_held_with_valid_inputs",
              32'({m_valid_o, m_last_o, m_data_o, m_id_o, s_ready_o}), 32'd0);
        rst = 1'b0;
        sample_valid(7, v, r0);
        check("rr_valid_pattern", 32'(v[6:0]), 32'b0110110);
        drain("rr_drain");

        // Only src1: two single-beat packets
        load(1, 4'h3, 1'b1); load(1, 4'h4, 1'b1);
        expect_beat(4'h3, 1'b1, 1'b1); expect_beat(4'h4, 1'b1, 1'b1);
        sample_valid(5, v, r0);
        check("single_beat_valid_pattern", 32'(v[4:0]), 32'b01010);
        check("src0_ready_never", 32'(r0), 32'd0);
        drain("single_drain");

        // Backpressure on beat 0x6 while src1 waits
        load(0, 4'h5, 1'b0); load(0, 4'h6, 1'b0); load(0, 4'h7, 1'b1);
        load(1, 4'hF, 1'b1);
        expect_beat(4'h5, 1'b0, 1'b0); expect_beat(4'h6, 1'b0, 1'b0);
        expect_beat(4'h7, 1'b1, 1'b0); expect_beat(4'hF, 1'b1, 1'b1);
        tick();
        tick();
        m_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) m_ready_i = 1'b1;
            #4;
            check("bp_hold{valid,data,id,rdy1}",
                  32'({m_valid_o, m_data_o, m_id_o, s_ready_o[1]}), 32'({1'b1, 4'h6, 1'b0, 1'b0}));
            tick();
        end
        drain("bp_drain");

        // src0 drops valid mid-packet; src1 starts requesting meanwhile
        load(0, 4'h1, 1'b0); load(0, 4'h2, 1'b0); load(0, 4'h3, 1'b1);
        expect_beat(4'h1, 1'b0, 1'b0); expect_beat(4'h2, 1'b0, 1'b0);
        expect_beat(4'h3, 1'b1, 1'b0); expect_beat(4'hE, 1'b1, 1'b1);
        tick();
        tick();
        pause[0] = 1'b1;
        load(1, 4'hE, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #4;
            check("gap{valid,id,rdy1}", 32'({m_valid_o, m_id_o, s_ready_o[1]}), 32'b000);
            tick();
        end
        pause[0] = 1'b0;
        drain("gap_drain");

        // Reset while BUSY on src1 mid-packet
        load(1, 4'hC, 1'b0); load(1, 4'hD, 1'b0); load(1, 4'hE, 1'b1);
        expect_beat(4'hC, 1'b0, 1'b1);
        tick();
        tick();
        check("busy_src1_before_reset{valid,id}", 32'({m_valid_o, m_id_o}), 32'b11);
        rst = 1'b1;
        #1;
        check("reset_mid_packet_outputs",
              32'({m_valid_o, m_last_o, m_data_o, m_id_o, s_ready_o}), 32'd0);
        check("reset_mid_packet_sb", 32'(exp_q.size()), 32'd0);
        src_q[0].delete();
        src_q[1].delete();
        load(0, 4'h8, 1'b1); load(1, 4'h9, 1'b1);
        expect_beat(4'h8, 1'b1, 1'b0); expect_beat(4'h9, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        drain("post_reset_drain");

`ifdef STREAM_ARB_QOS_EN
        // Equal QoS: round-robin order
        s_qos_i = {2'd2, 2'd2};
        load(0, 4'h3, 1'b1); load(1, 4'h4, 1'b1);
        expect_beat(4'h3, 1'b1, 1'b0); expect_beat(4'h4, 1'b1, 1'b1);
        drain("qos_equal_drain");

        // Higher QoS on src1 overrides round-robin preference for src0
        s_qos_i = {2'd3, 2'd1};
        load(0, 4'h1, 1'b1); load(1, 4'h2, 1'b1);
        expect_beat(4'h2, 1'b1, 1'b1); expect_beat(4'h1, 1'b1, 1'b0);
        drain("qos_priority_drain");
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
